// File: rtl/pingpong_ball_seq.sv
// Ball position, ball-step timer and BCD score counters for the ping-pong game.
// Define GAMEOVER_BLINK_EN to blink all LEDs in game over instead of showing the winner's end.
module pingpong_ball_seq #(
  parameter int unsigned SLOW_DIV = 25000000,
  parameter int unsigned FAST_DIV = 12500000,
  parameter int unsigned CNT_W    = 25
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] CS,
  output logic [5:0] LED,
  output logic [3:0] SCOREA,
  output logic [3:0] SCOREB,
  output logic       STEP
);

  localparam logic [2:0] CS_SERVE  = 3'b000;
  localparam logic [2:0] CS_TO_B   = 3'b001;
  localparam logic [2:0] CS_TO_A   = 3'b010;
  localparam logic [2:0] CS_PT_A   = 3'b011;
  localparam logic [2:0] CS_PT_B   = 3'b100;
  localparam logic [2:0] CS_OVER   = 3'b101;
  localparam logic [2:0] CS_FAST_B = 3'b110;
  localparam logic [2:0] CS_FAST_A = 3'b111;

  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(SLOW_DIV - 1);
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(FAST_DIV - 1);
  localparam logic [5:0]       LED_A_END = 6'b000001;
  localparam logic [5:0]       LED_B_END = 6'b100000;
  localparam logic [3:0]       SCORE_MAX = 4'd9;

  logic [5:0]       led_q, led_d;
  logic [3:0]       scorea_q, scorea_d;
  logic [3:0]       scoreb_q, scoreb_d;
  logic             step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       pcs_q, pcs_d;

  logic             prev_moving;
  logic             shift_left;
  logic [CNT_W-1:0] div_last;
  logic             wrap;

  function automatic logic is_moving(input logic [2:0] code);
    return (code == CS_TO_B) || (code == CS_TO_A) ||
           (code == CS_FAST_B) || (code == CS_FAST_A);
  endfunction

  assign prev_moving = is_moving(pcs_q);
  assign shift_left  = (CS == CS_TO_B) || (CS == CS_FAST_B);
  assign div_last    = ((CS == CS_FAST_B) || (CS == CS_FAST_A)) ? FAST_LAST : SLOW_LAST;
  assign wrap        = (cnt_q == div_last);

  // Next-state logic; counter defaults to cleared so only running states advance it
  always_comb begin
    led_d    = led_q;
    scorea_d = scorea_q;
    scoreb_d = scoreb_q;
    step_d   = 1'b0;
    cnt_d    = '0;
    pcs_d    = CS;
    case (CS)
      CS_SERVE: led_d = '0;
      CS_TO_B, CS_TO_A, CS_FAST_B, CS_FAST_A: begin
        if (!prev_moving) begin
          led_d = shift_left ? LED_A_END : LED_B_END;
        end else if (CS == pcs_q) begin
          if (wrap) begin
            step_d = 1'b1;
            if (shift_left) led_d = led_q[5] ? led_q : {led_q[4:0], 1'b0};
            else            led_d = led_q[0] ? led_q : {1'b0, led_q[5:1]};
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      CS_PT_A: begin
        led_d = '0;
        if ((pcs_q != CS_PT_A) && (scorea_q != SCORE_MAX)) scorea_d = scorea_q + 4'd1;
      end
      CS_PT_B: begin
        led_d = '0;
        if ((pcs_q != CS_PT_B) && (scoreb_q != SCORE_MAX)) scoreb_d = scoreb_q + 4'd1;
      end
      CS_OVER: begin
        if ((pcs_q == CS_OVER) && !wrap) cnt_d = cnt_q + CNT_W'(1);
`ifdef GAMEOVER_BLINK_EN
        if (pcs_q != CS_OVER) begin
          led_d = '0;
        end else if (wrap) begin
          led_d  = ~led_q;
          step_d = 1'b1;
        end
`else
        if (scorea_q == SCORE_MAX)      led_d = LED_A_END;
        else if (scoreb_q == SCORE_MAX) led_d = LED_B_END;
        else                            led_d = '0;
`endif
      end
      default: led_d = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      led_q    <= '0;
      scorea_q <= '0;
      scoreb_q <= '0;
      step_q   <= 1'b0;
      cnt_q    <= '0;
      pcs_q    <= '0;
    end else begin
      led_q    <= led_d;
      scorea_q <= scorea_d;
      scoreb_q <= scoreb_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
      pcs_q    <= pcs_d;
    end
  end

  assign LED    = led_q;
  assign SCOREA = scorea_q;
  assign SCOREB = scoreb_q;
  assign STEP   = step_q;

endmodule

// File: tb/tb_pingpong_ball_seq.sv
// Directed bench for pingpong_ball_seq with SLOW_DIV=4, FAST_DIV=2.
module tb_pingpong_ball_seq;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [2:0] CS  = 3'b000;
  logic [5:0] LED;
  logic [3:0] SCOREA;
  logic [3:0] SCOREB;
  logic       STEP;

  int checks = 0;
  int errors = 0;

  pingpong_ball_seq #(.SLOW_DIV(4), .FAST_DIV(2), .CNT_W(3)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .LED(LED),
    .SCOREA(SCOREA), .SCOREB(SCOREB), .STEP(STEP)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1; CS = 3'b000;
    tick();
    if (LED !== 6'b000000) begin errors++; $display("FAIL reset_led LED=%b exp=000000", LED); end checks++;
    if (SCOREA !== 4'd0) begin errors++; $display("FAIL reset_scorea got=%0d exp=0", SCOREA); end checks++;
    if (SCOREB !== 4'd0) begin errors++; $display("FAIL reset_scoreb got=%0d exp=0", SCOREB); end checks++;
    if (STEP !== 1'b0) begin errors++; $display("FAIL reset_step got=%b exp=0", STEP); end checks++;
    RST = 1'b0;
  endtask

  task automatic test_serve_and_shift();
    logic [5:0] exp_led;
    CS = 3'b000; tick();
    CS = 3'b001; tick();
    exp_led = 6'b000001;
    if (LED !== exp_led) begin errors++; $display("FAIL load_led LED=%b exp=%b", LED, exp_led); end checks++;
    if (STEP !== 1'b0) begin errors++; $display("FAIL load_step got=%b exp=0", STEP); end checks++;
    for (int k = 1; k <= 5; k++) begin
      for (int j = 0; j < 3; j++) begin
        tick();
        if (LED !== exp_led || STEP !== 1'b0) begin
          errors++; $display("FAIL shift_wait LED=%b STEP=%b exp=%b/0", LED, STEP, exp_led);
        end
        checks++;
      end
      tick();
      exp_led = exp_led << 1;
      if (LED !== exp_led || STEP !== 1'b1) begin
        errors++; $display("FAIL shift_step LED=%b STEP=%b exp=%b/1", LED, STEP, exp_led);
      end
      checks++;
    end
    for (int j = 0; j < 8; j++) begin
      tick();
      if (LED !== 6'b100000) begin errors++; $display("FAIL saturate_left LED=%b exp=100000", LED); end checks++;
    end
  endtask

  task automatic test_return_and_speed();
    CS = 3'b000; tick();
    CS = 3'b001; tick();
    repeat (16) tick();
    if (LED !== 6'b010000 || STEP !== 1'b1) begin
      errors++; $display("FAIL pre_return LED=%b STEP=%b exp=010000/1", LED, STEP);
    end
    checks++;
    CS = 3'b010; tick();
    if (LED !== 6'b010000 || STEP !== 1'b0) begin
      errors++; $display("FAIL return_hold LED=%b STEP=%b exp=010000/0", LED, STEP);
    end
    checks++;
    repeat (3) tick();
    if (LED !== 6'b010000) begin errors++; $display("FAIL return_wait LED=%b exp=010000", LED); end checks++;
    tick();
    if (LED !== 6'b001000 || STEP !== 1'b1) begin
      errors++; $display("FAIL return_shift LED=%b STEP=%b exp=001000/1", LED, STEP);
    end
    checks++;
    CS = 3'b110; tick();
    if (LED !== 6'b001000 || STEP !== 1'b0) begin
      errors++; $display("FAIL smash_hold LED=%b STEP=%b exp=001000/0", LED, STEP);
    end
    checks++;
    tick();
    if (LED !== 6'b001000 || STEP !== 1'b0) begin
      errors++; $display("FAIL smash_wait LED=%b STEP=%b exp=001000/0", LED, STEP);
    end
    checks++;
    tick();
    if (LED !== 6'b010000 || STEP !== 1'b1) begin
      errors++; $display("FAIL fast_shift1 LED=%b STEP=%b exp=010000/1", LED, STEP);
    end
    checks++;
    tick(); tick();
    if (LED !== 6'b100000 || STEP !== 1'b1) begin
      errors++; $display("FAIL fast_shift2 LED=%b STEP=%b exp=100000/1", LED, STEP);
    end
    checks++;
  endtask

  task automatic test_point();
    CS = 3'b011; tick();
    if (SCOREA !== 4'd1) begin errors++; $display("FAIL point_a_entry got=%0d exp=1", SCOREA); end checks++;
    if (LED !== 6'b000000) begin errors++; $display("FAIL point_a_led LED=%b exp=000000", LED); end checks++;
    repeat (9) tick();
    if (SCOREA !== 4'd1) begin errors++; $display("FAIL point_a_once got=%0d exp=1", SCOREA); end checks++;
    CS = 3'b100;
    repeat (10) tick();
    if (SCOREB !== 4'd1) begin errors++; $display("FAIL point_b_once got=%0d exp=1", SCOREB); end checks++;
    if (SCOREA !== 4'd1) begin errors++; $display("FAIL point_b_keeps_a got=%0d exp=1", SCOREA); end checks++;
  endtask

  task automatic test_saturate_and_gameover();
    logic [3:0] exp_a;
    logic [5:0] exp_led;
    for (int i = 2; i <= 10; i++) begin
      CS = 3'b000; tick();
      CS = 3'b011; tick();
      exp_a = (i > 9) ? 4'd9 : 4'(i);
      if (SCOREA !== exp_a) begin errors++; $display("FAIL score_a_count got=%0d exp=%0d", SCOREA, exp_a); end
      checks++;
    end
    repeat (5) tick();
    if (SCOREA !== 4'd9) begin errors++; $display("FAIL score_a_sat got=%0d exp=9", SCOREA); end checks++;
    CS = 3'b101; tick();
`ifdef GAMEOVER_BLINK_EN
    exp_led = 6'b000000;
    if (LED !== exp_led) begin errors++; $display("FAIL over_entry LED=%b exp=000000", LED); end checks++;
    for (int k = 0; k < 3; k++) begin
      repeat (3) tick();
      if (LED !== exp_led || STEP !== 1'b0) begin
        errors++; $display("FAIL blink_wait LED=%b STEP=%b exp=%b/0", LED, STEP, exp_led);
      end
      checks++;
      tick();
      exp_led = ~exp_led;
      if (LED !== exp_led || STEP !== 1'b1) begin
        errors++; $display("FAIL blink_toggle LED=%b STEP=%b exp=%b/1", LED, STEP, exp_led);
      end
      checks++;
    end
`else
    exp_led = 6'b000001;
    for (int k = 0; k < 12; k++) begin
      if (LED !== exp_led || STEP !== 1'b0) begin
        errors++; $display("FAIL over_winner LED=%b STEP=%b exp=%b/0", LED, STEP, exp_led);
      end
      checks++;
      tick();
    end
`endif
    if (SCOREA !== 4'd9 || SCOREB !== 4'd1) begin
      errors++; $display("FAIL over_frozen A=%0d B=%0d exp=9/1", SCOREA, SCOREB);
    end
    checks++;
  endtask

  task automatic test_reset_midflight();
    RST = 1'b1; tick(); RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      CS = 3'b000; tick();
      CS = 3'b100; tick();
    end
    CS = 3'b000; tick();
    CS = 3'b010; tick();
    repeat (12) tick();
    CS = 3'b111; tick();
    if (LED !== 6'b000100 || SCOREB !== 4'd3) begin
      errors++; $display("FAIL pre_rst LED=%b B=%0d exp=000100/3", LED, SCOREB);
    end
    checks++;
    RST = 1'b1; tick();
    if (LED !== 6'b000000) begin errors++; $display("FAIL rst_led LED=%b exp=000000", LED); end checks++;
    if (SCOREA !== 4'd0 || SCOREB !== 4'd0) begin
      errors++; $display("FAIL rst_scores A=%0d B=%0d exp=0/0", SCOREA, SCOREB);
    end
    checks++;
    if (STEP !== 1'b0) begin errors++; $display("FAIL rst_step got=%b exp=0", STEP); end checks++;
    RST = 1'b0; CS = 3'b010; tick();
    if (LED !== 6'b100000 || STEP !== 1'b0) begin
      errors++; $display("FAIL post_rst_load LED=%b STEP=%b exp=100000/0", LED, STEP);
    end
    checks++;
  endtask

  task automatic test_reentry();
    CS = 3'b000; tick();
    CS = 3'b001; tick();
    tick(); tick();
    CS = 3'b000; tick();
    if (LED !== 6'b000000) begin errors++; $display("FAIL serve_clear LED=%b exp=000000", LED); end checks++;
    CS = 3'b001; tick();
    if (LED !== 6'b000001 || STEP !== 1'b0) begin
      errors++; $display("FAIL reentry_load LED=%b STEP=%b exp=000001/0", LED, STEP);
    end
    checks++;
    repeat (3) tick();
    if (LED !== 6'b000001 || STEP !== 1'b0) begin
      errors++; $display("FAIL reentry_wait LED=%b STEP=%b exp=000001/0", LED, STEP);
    end
    checks++;
    tick();
    if (LED !== 6'b000010 || STEP !== 1'b1) begin
      errors++; $display("FAIL reentry_shift LED=%b STEP=%b exp=000010/1", LED, STEP);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_serve_and_shift();
    test_return_and_speed();
    test_point();
    test_saturate_and_gameover();
    test_reset_midflight();
    test_reentry();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_ball_seq.md
Name: pingpong_ball_seq

Overview:
- Sequencing datapath for the ping-pong game.
- Takes the 3-bit game state code CS from the game state register and drives three things:
  - the 6-LED one-hot ball position (LED);
  - a speed-dependent ball-step timer;
  - the two BCD score counters (SCOREA, SCOREB).
- LED, SCOREA and SCOREB feed back into the next-state logic.

Parameters:
- SLOW_DIV, 25000000, CLK cycles per ball step in normal-speed states (001, 010).
- FAST_DIV, 12500000, CLK cycles per ball step in smash states (110, 111).
- CNT_W, 25, divider counter width; must hold max(SLOW_DIV, FAST_DIV)-1.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- CS  input  3  current game state code.
- LED  output  6  one-hot ball position; LED[0] is A's end, LED[5] is B's end.
- SCOREA  output  4  player A score, BCD 0-9.
- SCOREB  output  4  player B score, BCD 0-9.
- STEP  output  1  one-cycle pulse on every cycle in which LED shifts.

Behaviour:
- Interface:
  - One clock, CLK. Reset RST is synchronous and active-high.
  - All outputs are registered.
- Reset values: LED=000000, SCOREA=0000, SCOREB=0000, STEP=0. The divider counter and the internal previous-state register PCS also clear to 0.
- State code meanings:
  - 000 = serve wait.
  - 001 = normal ball moving toward B (left shift).
  - 010 = normal ball moving toward A (right shift).
  - 110 = fast ball toward B.
  - 111 = fast ball toward A.
  - 011 = point to A.
  - 100 = point to B.
  - 101 = game over.
- Definitions:
  - A "moving" state is any of 001, 010, 110, 111.
  - PCS holds the CS value from the previous cycle.
- Entry into a moving state from a non-moving PCS:
  - CS=001 loads LED=000001; CS=010 loads LED=100000. The load takes effect on the next clock edge.
  - Counter is cleared to 0. No STEP on the load cycle.
- Transition between two moving states where CS≠PCS (return, smash, speed change):
  - LED holds its current value.
  - Counter is cleared to 0.
  - No STEP that cycle.
- Steady moving state (CS==PCS):
  - Counter increments each cycle.
  - When counter==DIV-1, where DIV is SLOW_DIV for 001/010 and FAST_DIV for 110/111: counter wraps to 0, STEP=1, and LED shifts on the same edge.
- Shift rules:
  - 001/110 shift left; 010/111 shift right.
  - Saturating: LED never leaves the 6-bit field. LED=100000 holds in left-shift states; LED=000001 holds in right-shift states.
  - The state logic detects the miss from the saturated value.
- State 000: LED=000000, counter held at 0.
- State 011: on the first cycle (PCS≠011), SCOREA increments by 1, saturating at 1001. LED=000000 and counter=0 while CS remains 011.
- State 100: same as 011, but SCOREB increments.
- Increment exactly once per entry, regardless of how long CS remains in the point state.
- State 101: scores frozen; LED per the optional feature; counter runs at SLOW_DIV period.
- Scores change only on point-state entry or RST. Values above 9 are never produced.
- RST during any state: all registers reset on that edge; RST has priority over every other update.
- Latency: CS change to LED/score update is 1 CLK.

Optional Feature:
- Macro: GAMEOVER_BLINK_EN.
- Defined: in state 101, LED toggles between 111111 and 000000 on every SLOW_DIV wrap; STEP pulses at each toggle. LED starts at 000000 on entry to 101.
- Undefined: in state 101, LED shows the winner's end, constant, and STEP stays 0:
  - LED=000001 if SCOREA==1001;
  - LED=100000 if SCOREB==1001;
  - 000000 otherwise.

Test Plan:
- SLOW_DIV=4, FAST_DIV=2. Reset; CS=000→001 held → LED=000001 after 1 cycle, then 000010, 000100, … 100000 every 4 cycles; STEP pulses coincide with each shift; LED holds at 100000.
- CS 001→010 at LED=010000 → LED stays 010000 with counter cleared; LED=001000 4 cycles later. CS 010→110 at LED=001000 (speed change) → LED holds, counter cleared, then shifts left every 2 cycles.
- CS=011 held 10 cycles → SCOREA increments exactly once (0→1), LED=000000. Repeat with CS=100 → SCOREB 0→1.
- Nine point-A entries, then a tenth → SCOREA stays 1001. CS=101 → without macro LED=000001 constant; with GAMEOVER_BLINK_EN LED alternates 000000/111111 every 4 cycles.
- RST asserted mid-flight (CS=111, LED=000100, SCOREB=0011) → next edge gives LED=000000, scores 0, STEP=0. With CS=010 after RST release, LED loads 100000.
- CS 001→000→001 → second entry reloads LED=000001 and restarts the counter, with no STEP on the load cycle.
